// File: rtl/ls_l_iter_if.sv
// Operand/result handshake bundle for the iterative left shifter.
// The master drives operands and takes results; the slave is the shifter.
interface ls_l_iter_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] indata;
    logic [SHW-1:0]   shift;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] outdata;

    modport master (
        output in_valid, indata, shift, out_ready,
        input  in_ready, out_valid, outdata
    );

    modport slave (
        input  in_valid, indata, shift, out_ready,
        output in_ready, out_valid, outdata
    );
endinterface

// File: rtl/ls_l_iter.sv
// Iterative logical left shifter: one power-of-two stage per clock
// (2**(SHW-1) down to 1), operand in and result out over valid/ready.
// WIDTH must equal 2**SHW.
module ls_l_iter #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic       clk,
    input  logic       rst,
    ls_l_iter_if.slave bus,
    output logic       busy
);
    localparam int KW = (SHW > 1) ? $clog2(SHW) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] acc;
    logic [SHW-1:0]   amt;
    logic [KW-1:0]    k;
    logic             out_valid;
    logic             accept;
    logic [WIDTH-1:0] stage_result;

    // Reset wins over an offered operand because in_ready is forced low.
    assign bus.in_ready  = (state == IDLE) && !rst;
    assign accept        = bus.in_valid && bus.in_ready;
    assign busy          = (state != IDLE);
    assign bus.out_valid = out_valid;
    assign bus.outdata   = acc;

    // Current stage: shift by 2**k only when that bit of the amount is set.
    always_comb begin
        stage_result = acc;
        if (amt[k]) begin
            stage_result = acc << (1 << k);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept -> five stages -> hold until taken.
    always_comb begin
        // NOTE: default first so no path through the case leaves
        // state_next unassigned, which would infer a latch.
        state_next = state;
        case (state)
            IDLE:    if (accept)                      state_next = SHIFT;
            SHIFT:   if (k == '0)                     state_next = DONE;
            DONE:    if (bus.out_ready)               state_next = IDLE;
            default:                                  state_next = IDLE;
        endcase
    end

    // Datapath: capture on accept, one stage per SHIFT cycle, flag result.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            amt       <= '0;
            k         <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc <= bus.indata;
                        amt <= bus.shift;
                        k   <= KW'(SHW - 1);
                    end
                end
                SHIFT: begin
                    acc <= stage_result;
                    if (k == '0) begin
                        out_valid <= 1'b1;
                    end else begin
                        k <= k - 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ls_l_iter.sv
// Self-checking bench for ls_l_iter: directed cases plus a random-data
// sweep of all shift amounts against a plain arithmetic model.
module tb_ls_l_iter;
    localparam int WIDTH = 32;
    localparam int SHW   = 5;
    localparam int LAT   = 5;

    logic clk;
    logic rst;
    logic busy;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    ls_l_iter_if #(.WIDTH(WIDTH), .SHW(SHW)) bus ();

    ls_l_iter #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: a logical left shift modulo 2**WIDTH.
    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] d, input int sh);
        logic [2*WIDTH-1:0] wide;
        wide = {{WIDTH{1'b0}}, d} << sh;
        return wide[WIDTH-1:0];
    endfunction

    // Offer one operand at the current negedge; return at the negedge after the accept edge.
    task automatic accept_op(input logic [WIDTH-1:0] d, input logic [SHW-1:0] sh);
        bus.in_valid = 1'b1;
        bus.indata   = d;
        bus.shift    = sh;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Count edges after the accept edge until out_valid; bounded.
    task automatic wait_result(output logic [WIDTH-1:0] res, output int lat, output bit busy_ok);
        lat     = 0;
        busy_ok = busy;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
            if (!busy) busy_ok = 1'b0;
        end
        res = bus.outdata;
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.indata    = 32'hA5A5_A5A5;
        bus.shift     = 5'd3;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b want=0", bus.in_ready); end
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        n_checks++;
        if (bus.outdata !== 32'h0) begin n_fail++; $display("FAIL reset_outdata got=%h want=0", bus.outdata); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_in_ready got=%b want=1", bus.in_ready); end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_no_capture_busy got=%b want=0", busy); end
    endtask

    task automatic test_shift31();
        logic [WIDTH-1:0] res;
        int lat;
        bit bok;
        accept_op(32'h0000_0001, 5'd31);
        wait_result(res, lat, bok);
        n_checks++;
        if (lat != LAT) begin n_fail++; $display("FAIL shift31_latency got=%0d want=%0d", lat, LAT); end
        n_checks++;
        if (res !== 32'h8000_0000) begin n_fail++; $display("FAIL shift31_data got=%h want=80000000", res); end
        release_result();
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL shift31_idle in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_zero_shift();
        logic [WIDTH-1:0] res;
        int lat;
        bit bok;
        accept_op(32'hFFFF_FFFF, 5'd0);
        wait_result(res, lat, bok);
        n_checks++;
        if (lat != LAT) begin n_fail++; $display("FAIL zero_latency got=%0d want=%0d", lat, LAT); end
        n_checks++;
        if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL zero_data got=%h want=ffffffff", res); end
        n_checks++;
        if (!bok) begin n_fail++; $display("FAIL zero_busy got=low during operation want=high"); end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || bus.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL zero_done_hold busy=%b out_valid=%b want 1/1", busy, bus.out_valid);
        end
        release_result();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy_after got=%b want=0", busy); end
    endtask

    task automatic test_mixed_sweep();
        logic [WIDTH-1:0] res;
        logic [WIDTH-1:0] d;
        int lat;
        bit bok;
        accept_op(32'hDEAD_BEEF, 5'd13);
        wait_result(res, lat, bok);
        n_checks++;
        if (res !== 32'hB7DD_E000) begin n_fail++; $display("FAIL mixed_data got=%h want=b7dde000", res); end
        release_result();
        for (int sh = 0; sh < 32; sh++) begin
            d = $urandom;
            accept_op(d, SHW'(sh));
            wait_result(res, lat, bok);
            n_checks++;
            if (res !== model(d, sh)) begin
                n_fail++; $display("FAIL sweep_data sh=%0d in=%h got=%h want=%h", sh, d, res, model(d, sh));
            end
            n_checks++;
            if (lat != LAT) begin n_fail++; $display("FAIL sweep_latency sh=%0d got=%0d want=%0d", sh, lat, LAT); end
            release_result();
        end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] res;
        logic [WIDTH-1:0] d0;
        logic [WIDTH-1:0] d1;
        logic [SHW-1:0]   s0;
        logic [SHW-1:0]   s1;
        int lat;
        bit bok;
        d0 = $urandom;
        s0 = SHW'($urandom_range(1, 31));
        d1 = $urandom;
        s1 = SHW'($urandom_range(1, 31));
        accept_op(d0, s0);
        wait_result(res, lat, bok);
        bus.in_valid = 1'b1;
        bus.indata   = d1;
        bus.shift    = s1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.outdata !== model(d0, s0) || bus.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold cyc=%0d out_valid=%b outdata=%h in_ready=%b want 1/%h/0",
                         i, bus.out_valid, bus.outdata, bus.in_ready, model(d0, s0));
            end
        end
        release_result();
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_idle in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_result(res, lat, bok);
        n_checks++;
        if (res !== model(d1, s1) || lat != LAT) begin
            n_fail++; $display("FAIL bp_next got=%h lat=%0d want=%h lat=%0d", res, lat, model(d1, s1), LAT);
        end
        release_result();
    endtask

    task automatic test_reset_mid_shift();
        bit seen_valid;
        accept_op(32'h1234_5679, 5'd2);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.outdata !== 32'h0 || bus.in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_state out_valid=%b outdata=%h in_ready=%b busy=%b want 0/0/1/0",
                     bus.out_valid, bus.outdata, bus.in_ready, busy);
        end
        seen_valid = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.out_valid) seen_valid = 1'b1;
        end
        n_checks++;
        if (seen_valid) begin n_fail++; $display("FAIL abort_no_result got=out_valid pulse want=none"); end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] ops_d[2];
        logic [SHW-1:0]   ops_s[2];
        int               acc_cyc[$];
        logic [WIDTH-1:0] res_q[$];
        int  idx;
        bit  pending;
        ops_d[0] = 32'h1; ops_s[0] = 5'd4;
        ops_d[1] = 32'h3; ops_s[1] = 5'd8;
        idx           = 0;
        pending       = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.indata    = ops_d[0];
        bus.shift     = ops_s[0];
        for (int n = 0; n < 30; n++) begin
            if (bus.out_valid) res_q.push_back(bus.outdata);
            if (bus.in_valid && bus.in_ready) begin
                acc_cyc.push_back(cyc);
                pending = 1'b1;
            end
            @(negedge clk);
            if (pending) begin
                pending = 1'b0;
                idx++;
                if (idx < 2) begin
                    bus.indata = ops_d[idx];
                    bus.shift  = ops_s[idx];
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
        end
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        n_checks++;
        if (acc_cyc.size() != 2 || res_q.size() != 2) begin
            n_fail++; $display("FAIL b2b_counts accepts=%0d results=%0d want 2/2", acc_cyc.size(), res_q.size());
        end else begin
            n_checks++;
            if (acc_cyc[1] - acc_cyc[0] != 7) begin
                n_fail++; $display("FAIL b2b_spacing got=%0d want=7", acc_cyc[1] - acc_cyc[0]);
            end
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (res_q[i] !== model(ops_d[i], int'(ops_s[i]))) begin
                    n_fail++; $display("FAIL b2b_data idx=%0d got=%h want=%h", i, res_q[i], model(ops_d[i], int'(ops_s[i])));
                end
            end
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.indata    = '0;
        bus.shift     = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_shift31();
        test_zero_shift();
        test_mixed_sweep();
        test_backpressure();
        test_reset_mid_shift();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
